// File: rtl/hd44780_pkg.sv
// Shared constants, types and helpers for the HD44780 bus receiver.
`timescale 1ns/1ps
package hd44780_pkg;

    localparam logic [7:0] CLR_MASK    = 8'hFF;
    localparam logic [7:0] CLR_MATCH   = 8'h01;
    localparam logic [7:0] HOME_MASK   = 8'hFE;
    localparam logic [7:0] HOME_MATCH  = 8'h02;
    localparam logic [7:0] ENTRY_MASK  = 8'hFC;
    localparam logic [7:0] ENTRY_MATCH = 8'h04;
    localparam logic [7:0] DISP_MASK   = 8'hF8;
    localparam logic [7:0] DISP_MATCH  = 8'h08;
    localparam logic [7:0] SHIFT_MASK  = 8'hF0;
    localparam logic [7:0] SHIFT_MATCH = 8'h10;
    localparam logic [7:0] FUNC_MASK   = 8'hE0;
    localparam logic [7:0] FUNC_MATCH  = 8'h20;
    localparam logic [7:0] CGRAM_MASK  = 8'hC0;
    localparam logic [7:0] CGRAM_MATCH = 8'h40;
    localparam logic [7:0] DDRAM_MASK  = 8'h80;
    localparam logic [7:0] DDRAM_MATCH = 8'h80;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [6:0] ROW0_BASE = 7'h00;
    localparam logic [6:0] ROW1_BASE = 7'h40;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef enum logic [3:0] {
        I_NOP,
        I_CLR,
        I_HOME,
        I_ENTRY,
        I_DISP,
        I_SHIFT,
        I_FUNC,
        I_CGRAM,
        I_DDRAM
    } instr_t;

    // Mask/match ranges are disjoint, so the highest set bit selects exactly one.
    function automatic instr_t decode_instr(input logic [7:0] b);
        instr_t t;
        t = I_NOP;
        unique case (1'b1)
            ((b & DDRAM_MASK) == DDRAM_MATCH): t = I_DDRAM;
            ((b & CGRAM_MASK) == CGRAM_MATCH): t = I_CGRAM;
            ((b & FUNC_MASK)  == FUNC_MATCH):  t = I_FUNC;
            ((b & SHIFT_MASK) == SHIFT_MATCH): t = I_SHIFT;
            ((b & DISP_MASK)  == DISP_MATCH):  t = I_DISP;
            ((b & ENTRY_MASK) == ENTRY_MATCH): t = I_ENTRY;
            ((b & HOME_MASK)  == HOME_MATCH):  t = I_HOME;
            ((b & CLR_MASK)   == CLR_MATCH):   t = I_CLR;
            default:                           t = I_NOP;
        endcase
        return t;
    endfunction

    function automatic logic [4:0] ac_step(
        input logic [4:0] ac,
        input logic       id,
        input logic [4:0] last
    );
        if (id)
            return (ac == last) ? 5'd0 : ac + 5'd1;
        return (ac == 5'd0) ? last : ac - 5'd1;
    endfunction

endpackage

// File: rtl/hd44780_bus_sync.sv
// Synchronizer chain for the LCD bus plus EN falling-edge detector.
// o_en exists only when HD44780_RX_READBACK_EN is defined.
`timescale 1ns/1ps
module hd44780_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_50MHz,
    input  logic       resetn,
    input  logic       i_en,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_data,
`ifdef HD44780_RX_READBACK_EN
    output logic       o_en,
`endif
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data,
    output logic       o_fall
);

    logic [10:0] r_sync [SYNC_STAGES];
    logic        r_en_d;
    logic        w_en;

    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_sync[0] <= {i_en, i_rs, i_rw, i_data};
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_en_d <= w_en;
        end
    end

    assign {w_en, o_rs, o_rw, o_data} = r_sync[SYNC_STAGES-1];
    // RS/DATA come from the same sample that shows EN low.
    assign o_fall = r_en_d & ~w_en;

`ifdef HD44780_RX_READBACK_EN
    assign o_en = w_en;
`endif

endmodule

// File: rtl/hd44780_bus_receiver.sv
// HD44780 bus listener: decodes writes into a 2-row DDRAM shadow.
// Optional bus readback is enabled by HD44780_RX_READBACK_EN.
`timescale 1ns/1ps
module hd44780_bus_receiver
    import hd44780_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 16,
    parameter int CLR_CYCLES  = 32
) (
    input  logic       CLK_50MHz,
    input  logic       resetn,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] addr_cnt,
    output logic       disp_on,
    output logic       busy,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_val,
    output logic       err_addr,
    output logic       err_overrun
`ifdef HD44780_RX_READBACK_EN
    ,
    output logic [7:0] rd_bus_data,
    output logic       rd_bus_oe
`endif
);

    localparam int         DEPTH = 2 * COLS;
    localparam int         CW    = $clog2(CLR_CYCLES) + 1;
    localparam logic [4:0] LAST  = 5'(DEPTH - 1);

    logic         w_rs;
    logic         w_rw;
    logic [7:0]   w_data;
    logic         w_fall;
    logic         w_wr_stb;
    instr_t       w_instr;
    logic [5:0]   w_col;
    logic         w_row;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [CW-1:0] r_clr_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [4:0]   r_ac;
    logic [4:0]   w_ac_nxt;
    logic         r_id;
    logic         w_id_nxt;
    logic         r_disp;
    logic         w_disp_nxt;
    logic         r_err_addr;
    logic         r_err_ovr;
    logic         w_set_err_addr;
    logic         w_set_ovr;
    logic         r_bvalid;
    logic         r_brs;
    logic [7:0]   r_bval;
    logic [7:0]   r_rd_char;
    logic         w_we;
    logic [4:0]   w_waddr;
    logic [7:0]   w_wdata;
    logic [7:0]   r_ddram [DEPTH];

`ifdef HD44780_RX_READBACK_EN
    logic         w_en;
    logic         w_rd_stb;
`endif

    hd44780_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK_50MHz (CLK_50MHz),
        .resetn    (resetn),
        .i_en      (LCD_EN),
        .i_rs      (LCD_RS),
        .i_rw      (LCD_RW),
        .i_data    (LCD_DATA),
`ifdef HD44780_RX_READBACK_EN
        .o_en      (w_en),
`endif
        .o_rs      (w_rs),
        .o_rw      (w_rw),
        .o_data    (w_data),
        .o_fall    (w_fall)
    );

    assign w_wr_stb = w_fall & ~w_rw;
    assign w_instr  = decode_instr(w_data);
    assign w_row    = w_data[6];
    assign w_col    = 6'(w_data[6:0] - (w_row ? ROW1_BASE : ROW0_BASE));

`ifdef HD44780_RX_READBACK_EN
    assign w_rd_stb = w_fall & w_rw;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_clr_cnt;
        w_ac_nxt       = r_ac;
        w_id_nxt       = r_id;
        w_disp_nxt     = r_disp;
        w_we           = 1'b0;
        w_waddr        = r_ac;
        w_wdata        = w_data;
        w_set_err_addr = 1'b0;
        w_set_ovr      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr_stb && w_rs) begin
                    w_we     = 1'b1;
                    w_ac_nxt = ac_step(r_ac, r_id, LAST);
                end else if (w_wr_stb) begin
                    unique case (w_instr)
                        I_DDRAM: begin
                            if (w_col[5:4] != 2'b00)
                                w_set_err_addr = 1'b1;
                            else
                                w_ac_nxt = {w_row, w_col[3:0]};
                        end
                        I_DISP:  w_disp_nxt = w_data[2];
                        I_ENTRY: w_id_nxt   = w_data[1];
                        I_HOME:  w_ac_nxt   = 5'd0;
                        I_CLR: begin
                            w_state_nxt = ST_CLEAR;
                            w_cnt_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
`ifdef HD44780_RX_READBACK_EN
                else if (w_rd_stb && w_rs) begin
                    w_ac_nxt = ac_step(r_ac, r_id, LAST);
                end
`endif
            end
            ST_CLEAR: begin
                if (w_wr_stb)
                    w_set_ovr = 1'b1;
                if (r_clr_cnt < CW'(DEPTH)) begin
                    w_we    = 1'b1;
                    w_waddr = r_clr_cnt[4:0];
                    w_wdata = ASCII_SPACE;
                end
                if (r_clr_cnt == CW'(CLR_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_ac_nxt    = 5'd0;
                    w_id_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_ac       <= 5'd0;
            r_id       <= 1'b1;
            r_disp     <= 1'b0;
            r_err_addr <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_brs      <= 1'b0;
            r_bval     <= 8'h00;
            r_rd_char  <= ASCII_SPACE;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_cnt_nxt;
            r_ac       <= w_ac_nxt;
            r_id       <= w_id_nxt;
            r_disp     <= w_disp_nxt;
            r_err_addr <= r_err_addr | w_set_err_addr;
            r_err_ovr  <= r_err_ovr | w_set_ovr;
            r_bvalid   <= w_wr_stb;
            if (w_wr_stb) begin
                r_brs  <= w_rs;
                r_bval <= w_data;
            end
            r_rd_char  <= r_ddram[rd_addr];
        end
    end

    // Shadow memory is intentionally not reset; only Clear Display fills it.
    always_ff @(posedge CLK_50MHz) begin
        if (w_we)
            r_ddram[w_waddr] <= w_wdata;
    end

`ifdef HD44780_RX_READBACK_EN
    always_comb begin
        rd_bus_oe   = 1'b0;
        rd_bus_data = 8'h00;
        if (w_en && w_rw) begin
            rd_bus_oe   = 1'b1;
            rd_bus_data = w_rs ? r_ddram[r_ac]
                               : {(r_state == ST_CLEAR), 2'b00, r_ac};
        end
    end
`endif

    assign rd_char     = r_rd_char;
    assign addr_cnt    = r_ac;
    assign disp_on     = r_disp;
    assign busy        = (r_state == ST_CLEAR);
    assign byte_valid  = r_bvalid;
    assign byte_rs     = r_brs;
    assign byte_val    = r_bval;
    assign err_addr    = r_err_addr;
    assign err_overrun = r_err_ovr;

endmodule
